// File: rtl/flash.sv
// rtl/flash.sv - single-transaction parallel NOR flash bus controller
//
// Runs one byte write or byte read per fb_start handshake and generates the
// CE#/OE#/WE# strobe sequence with fixed, clock-counted widths.
//
// Ports:
//   RST, CLK_50MHZ      asynchronous active-high reset, 50 MHz clock
//   NF_CE/NF_OE/NF_WE   flash strobes, active low, registered
//   NF_BYTE/NF_RP/NF_WP fixed straps (x8 mode, out of reset, unprotected)
//   NF_STS              flash status, not used
//   NF_A, NF_D          flash address bus and bidirectional data bus
//   addr, data          request address and write data
//   direction_rw        0 = write, 1 = read
//   fb_start, fb_done   one-clock request strobe and completion pulse
module flash #(
  parameter int WE_CYCLES = 4,
  parameter int RD_CYCLES = 6
) (
  input  logic       RST,
  input  logic       CLK_50MHZ,
  output logic       NF_CE,
  output logic       NF_BYTE,
  output logic       NF_OE,
  output logic       NF_RP,
  output logic       NF_WE,
  output logic       NF_WP,
  input  logic       NF_STS,
  output logic [7:0] NF_A,
  inout  wire  [7:0] NF_D,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       direction_rw,
  input  logic       fb_start,
  output logic       fb_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] d_out;
  logic       d_oe;
  logic       rw_q;
  logic [7:0] rd_data;

  // Status pin is deliberately ignored; no program/erase polling is done.
  logic unused_sts;
  assign unused_sts = NF_STS;

  assign NF_BYTE = 1'b0;
  assign NF_RP   = 1'b1;
  assign NF_WP   = 1'b1;

  assign NF_D = d_oe ? d_out : 8'hzz;

  // Strobes and the bus enable are updated on the same edge as the state
  // change, so every pin comes straight from a flop.
  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      NF_CE   <= 1'b1;
      NF_OE   <= 1'b1;
      NF_WE   <= 1'b1;
      NF_A    <= 8'h00;
      d_out   <= 8'h00;
      d_oe    <= 1'b0;
      rw_q    <= 1'b0;
      cnt     <= 8'h00;
      fb_done <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          fb_done <= 1'b0;
          if (fb_start) begin
            NF_A  <= addr;
            d_out <= data;
            rw_q  <= direction_rw;
            NF_CE <= 1'b0;
            // Write data goes on the bus one clock ahead of WE# for setup.
            d_oe  <= ~direction_rw;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (rw_q) begin
            NF_OE <= 1'b0;
            cnt   <= 8'(RD_CYCLES - 1);
            state <= READ;
          end else begin
            NF_WE <= 1'b0;
            cnt   <= 8'(WE_CYCLES - 1);
            state <= WRITE;
          end
        end
        WRITE: begin
          if (cnt == 8'h00) begin
            NF_WE <= 1'b1;
            NF_CE <= 1'b1;
            state <= HOLD;
          end else begin
            cnt <= cnt - 8'h01;
          end
        end
        READ: begin
          if (cnt == 8'h00) begin
            // Sample on the same edge OE# rises, at the end of access time.
            rd_data <= NF_D;
            NF_OE   <= 1'b1;
            NF_CE   <= 1'b1;
            state   <= HOLD;
          end else begin
            cnt <= cnt - 8'h01;
          end
        end
        HOLD: begin
          // Write data is held one clock past WE# rising, then released.
          d_oe    <= 1'b0;
          fb_done <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          fb_done <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash.sv
// tb/tb_flash.sv - directed self-checking bench for the flash controller
module tb_flash;

  logic       rst;
  logic       clk;
  logic       nf_ce, nf_byte, nf_oe, nf_rp, nf_we, nf_wp;
  logic       nf_sts;
  logic [7:0] nf_a;
  wire  [7:0] nf_d;
  logic [7:0] addr, data;
  logic       direction_rw;
  logic       fb_start;
  logic       fb_done;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];

  // Flash model: drives the stored byte whenever it is selected for output.
  assign nf_d = (!nf_oe && !nf_ce) ? mem[nf_a] : 8'hzz;

  flash dut (
    .RST          (rst),
    .CLK_50MHZ    (clk),
    .NF_CE        (nf_ce),
    .NF_BYTE      (nf_byte),
    .NF_OE        (nf_oe),
    .NF_RP        (nf_rp),
    .NF_WE        (nf_we),
    .NF_WP        (nf_wp),
    .NF_STS       (nf_sts),
    .NF_A         (nf_a),
    .NF_D         (nf_d),
    .addr         (addr),
    .data         (data),
    .direction_rw (direction_rw),
    .fb_start     (fb_start),
    .fb_done      (fb_done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches 12 clocks after the accepting edge.
  // j counts negedges after the accepting edge k (j=0 is SETUP).
  task automatic run_txn(input logic [7:0] a, input logic [7:0] d, input logic rw,
                         input logic repulse,
                         output int we_low, output int oe_low, output int ce_low,
                         output int done_cnt, output int done_at,
                         output int a_bad, output int d_bad, output int oe_bad);
    we_low = 0; oe_low = 0; ce_low = 0; done_cnt = 0; done_at = -1;
    a_bad = 0; d_bad = 0; oe_bad = 0;
    @(negedge clk);
    addr = a; data = d; direction_rw = rw; fb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fb_start = 1'b0;
    for (int j = 0; j <= 12; j++) begin
      if (j > 0) @(negedge clk);
      if (!nf_ce) begin
        ce_low++;
        if (nf_a !== a) a_bad++;
      end
      if (!nf_we) begin
        we_low++;
        if (nf_d !== d) d_bad++;
      end
      if (!nf_oe) begin
        oe_low++;
        if (dut.d_oe !== 1'b0) oe_bad++;
      end
      if (fb_done) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (repulse && j == 2) begin
        addr = 8'h11; data = 8'h22; direction_rw = ~rw; fb_start = 1'b1;
      end
      if (repulse && j == 3) begin
        fb_start = 1'b0; addr = a; data = d; direction_rw = rw;
      end
    end
  endtask

  int we_low, oe_low, ce_low, done_cnt, done_at, a_bad, d_bad, oe_bad;
  int dn;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    nf_sts = 1'bx;
    addr = 8'h00; data = 8'h00; direction_rw = 1'b0; fb_start = 1'b0;

    // Reset
    rst = 1'b1;
    #50;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ce", {7'b0, nf_ce}, 8'h01);
    chk("rst_oe", {7'b0, nf_oe}, 8'h01);
    chk("rst_we", {7'b0, nf_we}, 8'h01);
    chk("rst_byte", {7'b0, nf_byte}, 8'h00);
    chk("rst_rp", {7'b0, nf_rp}, 8'h01);
    chk("rst_wp", {7'b0, nf_wp}, 8'h01);
    chk("rst_d_oe", {7'b0, dut.d_oe}, 8'h00);
    chk("rst_done", {7'b0, fb_done}, 8'h00);
    chk("rst_a", nf_a, 8'h00);
    chk("rst_rd_data", dut.rd_data, 8'h00);

    // Write 1
    run_txn(8'h35, 8'hC9, 1'b0, 1'b0, we_low, oe_low, ce_low, done_cnt, done_at, a_bad, d_bad, oe_bad);
    mem[8'h35] = 8'hC9;
    chk("w1_we_low", 8'(we_low), 8'd4);
    chk("w1_oe_low", 8'(oe_low), 8'd0);
    chk("w1_ce_low", 8'(ce_low), 8'd5);
    chk("w1_done_cnt", 8'(done_cnt), 8'd1);
    chk("w1_done_at", 8'(done_at), 8'd6);
    chk("w1_a_bad", 8'(a_bad), 8'd0);
    chk("w1_d_bad", 8'(d_bad), 8'd0);

    // Write 2
    run_txn(8'hF5, 8'h0D, 1'b0, 1'b0, we_low, oe_low, ce_low, done_cnt, done_at, a_bad, d_bad, oe_bad);
    mem[8'hF5] = 8'h0D;
    chk("w2_we_low", 8'(we_low), 8'd4);
    chk("w2_done_cnt", 8'(done_cnt), 8'd1);
    chk("w2_done_at", 8'(done_at), 8'd6);
    chk("w2_a_bad", 8'(a_bad), 8'd0);
    chk("w2_d_bad", 8'(d_bad), 8'd0);
    chk("w2_nf_a", nf_a, 8'hF5);

    // Read 1
    run_txn(8'h35, 8'h00, 1'b1, 1'b0, we_low, oe_low, ce_low, done_cnt, done_at, a_bad, d_bad, oe_bad);
    chk("r1_oe_low", 8'(oe_low), 8'd6);
    chk("r1_we_low", 8'(we_low), 8'd0);
    chk("r1_ce_low", 8'(ce_low), 8'd7);
    chk("r1_oe_bad", 8'(oe_bad), 8'd0);
    chk("r1_done_cnt", 8'(done_cnt), 8'd1);
    chk("r1_done_at", 8'(done_at), 8'd8);
    chk("r1_a_bad", 8'(a_bad), 8'd0);
    chk("r1_rd_data", dut.rd_data, 8'hC9);

    // fb_start re-pulsed during WRITE must be ignored
    run_txn(8'h5A, 8'h3C, 1'b0, 1'b1, we_low, oe_low, ce_low, done_cnt, done_at, a_bad, d_bad, oe_bad);
    mem[8'h5A] = 8'h3C;
    chk("rp_done_cnt", 8'(done_cnt), 8'd1);
    chk("rp_done_at", 8'(done_at), 8'd6);
    chk("rp_we_low", 8'(we_low), 8'd4);
    chk("rp_oe_low", 8'(oe_low), 8'd0);
    chk("rp_a_bad", 8'(a_bad), 8'd0);
    chk("rp_d_bad", 8'(d_bad), 8'd0);
    chk("rp_nf_a", nf_a, 8'h5A);

    // RST raised in the middle of READ
    @(negedge clk);
    addr = 8'hF5; direction_rw = 1'b1; fb_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fb_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_in_read_oe", {7'b0, nf_oe}, 8'h00);
    rst = 1'b1;
    #1;
    chk("mr_ce", {7'b0, nf_ce}, 8'h01);
    chk("mr_oe", {7'b0, nf_oe}, 8'h01);
    chk("mr_we", {7'b0, nf_we}, 8'h01);
    chk("mr_d_oe", {7'b0, dut.d_oe}, 8'h00);
    chk("mr_state", {5'b0, dut.state}, 8'h00);
    chk("mr_rd_data", dut.rd_data, 8'h00);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (fb_done) dn++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (fb_done) dn++;
    end
    chk("mr_no_done", 8'(dn), 8'd0);

    // Read back the second write after recovery
    run_txn(8'hF5, 8'h00, 1'b1, 1'b0, we_low, oe_low, ce_low, done_cnt, done_at, a_bad, d_bad, oe_bad);
    chk("r2_done_at", 8'(done_at), 8'd8);
    chk("r2_oe_low", 8'(oe_low), 8'd6);
    chk("r2_rd_data", dut.rd_data, 8'h0D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
